// File: rtl/ap_adder_sigmoid_pkg.sv
// Shared constants for the RBM activation slice: widths, saturation limits and
// the PLAN sigmoid breakpoints and offsets.
package rbm_pkg;

    localparam int DATA_W = 12;
    localparam int FRAC_W = 8;
    localparam int OUT_W  = 8;

    // |z| needs one extra bit so that |-2048| is representable.
    localparam int AW  = DATA_W + 1;
    localparam int F_W = 9;

    localparam logic signed [DATA_W-1:0] SAT_MAX = 12'sh7FF;
    localparam logic signed [DATA_W-1:0] SAT_MIN = 12'sh800;

    localparam logic [AW-1:0] BP1 = 13'd256;
    localparam logic [AW-1:0] BP2 = 13'd608;
    localparam logic [AW-1:0] BP3 = 13'd1280;

    localparam logic [F_W-1:0] OFF1 = 9'd128;
    localparam logic [F_W-1:0] OFF2 = 9'd160;
    localparam logic [F_W-1:0] OFF3 = 9'd216;
    localparam logic [F_W-1:0] ONE  = 9'd256;

endpackage

// File: rtl/ap_adder_sigmoid_if.sv
// Operand/result bundle between the accumulators, this slice and the sampler.
interface ap_adder_sigmoid_if;

    logic                               in_valid;
    logic signed [rbm_pkg::DATA_W-1:0]  x;
    logic signed [rbm_pkg::DATA_W-1:0]  y;
    logic                               sum_valid;
    logic signed [rbm_pkg::DATA_W-1:0]  z;
    logic                               sg_valid;
    logic [rbm_pkg::OUT_W-1:0]          sg_out;

    modport master (
        output in_valid, x, y,
        input  sum_valid, z, sg_valid, sg_out
    );

    modport slave (
        input  in_valid, x, y,
        output sum_valid, z, sg_valid, sg_out
    );

endinterface

// File: rtl/ap_adder_sigmoid_sigmoid.sv
// Combinational piecewise-linear sigmoid on a signed Q4.8 input, producing an
// unsigned Q0.8 probability; negative inputs use the mirror 1 - f(|z|).
module sigmoid
    import rbm_pkg::*;
(
    input  logic signed [DATA_W-1:0] z,
    output logic [OUT_W-1:0]         sg
);

    logic [AW-1:0]  w_zext;
    logic [AW-1:0]  w_a;
    logic [F_W-1:0] w_f;

    assign w_zext = {z[DATA_W-1], z};
    assign w_a    = z[DATA_W-1] ? (~w_zext + AW'(1)) : w_zext;

    always_comb begin
        w_f = ONE;
        if (w_a < BP1) begin
            w_f = OFF1 + F_W'(w_a >> 2);
        end else if (w_a < BP2) begin
            w_f = OFF2 + F_W'(w_a >> 3);
        end else if (w_a < BP3) begin
            w_f = OFF3 + F_W'(w_a >> 5);
        end
    end

    // Only the saturated region reaches 256, which clips to 255 on the positive side.
    always_comb begin
        sg = '0;
        if (!z[DATA_W-1]) begin
            sg = (w_f == ONE) ? {OUT_W{1'b1}} : w_f[OUT_W-1:0];
        end else begin
            sg = OUT_W'(ONE - w_f);
        end
    end

endmodule

// File: rtl/ap_adder_sigmoid.sv
// Two-stage activation pipeline: saturating add of x+y, then PLAN sigmoid of
// the registered sum. No backpressure; data registers update every cycle.
module ap_adder_sigmoid
    import rbm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    ap_adder_sigmoid_if.slave bus
);

    logic [DATA_W:0]          w_sum;
    logic signed [DATA_W-1:0] w_sat;
    logic [OUT_W-1:0]         w_sg;

    logic                     r_sum_valid;
    logic signed [DATA_W-1:0] r_z;
    logic                     r_sg_valid;
    logic [OUT_W-1:0]         r_sg_out;

    assign w_sum = {bus.x[DATA_W-1], bus.x} + {bus.y[DATA_W-1], bus.y};

    // Top two bits of the 13-bit sum disagree exactly when the result overflows 12 bits.
    always_comb begin
        w_sat = w_sum[DATA_W-1:0];
        if (w_sum[DATA_W:DATA_W-1] == 2'b01) begin
            w_sat = SAT_MAX;
        end else if (w_sum[DATA_W:DATA_W-1] == 2'b10) begin
            w_sat = SAT_MIN;
        end
    end

    sigmoid u_sigmoid (
        .z  (r_z),
        .sg (w_sg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum_valid <= 1'b0;
            r_z         <= '0;
            r_sg_valid  <= 1'b0;
            r_sg_out    <= '0;
        end else begin
            r_sum_valid <= bus.in_valid;
            r_z         <= w_sat;
            r_sg_valid  <= r_sum_valid;
            r_sg_out    <= w_sg;
        end
    end

    assign bus.sum_valid = r_sum_valid;
    assign bus.z         = r_z;
    assign bus.sg_valid  = r_sg_valid;
    assign bus.sg_out    = r_sg_out;

endmodule

// File: tb/tb_ap_adder_sigmoid.sv
// Bench for ap_adder_sigmoid: directed spec vectors, streaming, mid-stream
// reset and randomized traffic against an integer reference model.
module tb_ap_adder_sigmoid;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    int checks   = 0;
    int failures = 0;

    // Expected pipeline contents as seen after the most recent clock edge.
    logic [11:0] m_z   = '0;
    logic        m_zv  = 1'b0;
    logic [7:0]  m_sg  = '0;
    logic        m_sgv = 1'b0;

    ap_adder_sigmoid_if bus ();

    ap_adder_sigmoid dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] ref_sat(input int s);
        if (s > 2047)  return 12'h7FF;
        if (s < -2048) return 12'h800;
        return 12'(s);
    endfunction

    function automatic logic [7:0] ref_sig(input logic [11:0] zc);
        int zi, a, f;
        zi = int'($signed(zc));
        a  = (zi < 0) ? -zi : zi;
        if (a < 256)       f = 128 + a / 4;
        else if (a < 608)  f = 160 + a / 8;
        else if (a < 1280) f = 216 + a / 32;
        else               f = 256;
        if (zi >= 0) return 8'((f > 255) ? 255 : f);
        return 8'(256 - f);
    endfunction

    // Drive one input cycle, advance the reference model across the edge.
    task automatic step(input logic v, input logic [11:0] xa, input logic [11:0] ya);
        bus.in_valid = v;
        bus.x        = xa;
        bus.y        = ya;
        @(posedge clk);
        m_sg  = ref_sig(m_z);
        m_sgv = m_zv;
        m_z   = ref_sat(int'($signed(xa)) + int'($signed(ya)));
        m_zv  = v;
        #1;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.x = '0;
        bus.y = '0;
        #1 rst_n = 1'b0;
        #2;
        checks += 4;
        if (bus.sum_valid !== 1'b0) begin failures++; $display("FAIL reset_sum_valid got=%b want=0", bus.sum_valid); end
        if (bus.z !== 12'd0)        begin failures++; $display("FAIL reset_z got=%0d want=0", bus.z); end
        if (bus.sg_valid !== 1'b0)  begin failures++; $display("FAIL reset_sg_valid got=%b want=0", bus.sg_valid); end
        if (bus.sg_out !== 8'd0)    begin failures++; $display("FAIL reset_sg_out got=%0d want=0", bus.sg_out); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        m_z = '0; m_zv = 1'b0; m_sg = '0; m_sgv = 1'b0;
        $display("reset: sum_valid=%b z=%0d sg_valid=%b sg_out=%0d", bus.sum_valid, $signed(bus.z), bus.sg_valid, bus.sg_out);
    endtask

    task automatic test_directed();
        int tx [9] = '{2047,  10, -1000, 0, 256, -256, 607, 608, 1279};
        int ty [9] = '{3,     100, -1100, 0, 0,   0,    0,   0,   0};
        int tz [9] = '{2047,  110, -2048, 0, 256, -256, 607, 608, 1279};
        int ts [9] = '{255,   155, 0,     128, 192, 64, 235, 235, 255};
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 12'(tx[i]), 12'(ty[i]));
            checks += 2;
            if (bus.sum_valid !== 1'b1) begin failures++; $display("FAIL dir%0d_sum_valid got=%b want=1", i, bus.sum_valid); end
            if ($signed(bus.z) !== 12'(tz[i])) begin failures++; $display("FAIL dir%0d_z got=%0d want=%0d", i, $signed(bus.z), tz[i]); end
            step(1'b0, 12'd0, 12'd0);
            checks += 3;
            if (bus.sg_valid !== 1'b1) begin failures++; $display("FAIL dir%0d_sg_valid got=%b want=1", i, bus.sg_valid); end
            if (bus.sg_out !== 8'(ts[i])) begin failures++; $display("FAIL dir%0d_sg_out got=%0d want=%0d", i, bus.sg_out, ts[i]); end
            if (bus.sum_valid !== 1'b0) begin failures++; $display("FAIL dir%0d_bubble got=%b want=0", i, bus.sum_valid); end
            $display("directed x=%0d y=%0d -> z=%0d sg_out=%0d", tx[i], ty[i], tz[i], bus.sg_out);
        end
    endtask

    task automatic test_back_to_back();
        int sx [4] = '{1, -5, 300, -2048};
        int sy [4] = '{2, 5, 300, -1};
        int sz [4] = '{3, 0, 600, -2048};
        int ss [4] = '{128, 128, 235, 0};
        for (int i = 0; i < 6; i++) begin
            if (i < 4) step(1'b1, 12'(sx[i]), 12'(sy[i]));
            else       step(1'b0, 12'd0, 12'd0);
            checks += 2;
            if (bus.sum_valid !== (i < 4)) begin failures++; $display("FAIL stream%0d_sum_valid got=%b want=%b", i, bus.sum_valid, i < 4); end
            if (bus.sg_valid !== (i >= 1 && i <= 4)) begin failures++; $display("FAIL stream%0d_sg_valid got=%b want=%b", i, bus.sg_valid, i >= 1 && i <= 4); end
            if (i < 4) begin
                checks++;
                if ($signed(bus.z) !== 12'(sz[i])) begin failures++; $display("FAIL stream%0d_z got=%0d want=%0d", i, $signed(bus.z), sz[i]); end
            end
            if (i >= 1 && i <= 4) begin
                checks++;
                if (bus.sg_out !== 8'(ss[i-1])) begin failures++; $display("FAIL stream%0d_sg_out got=%0d want=%0d", i, bus.sg_out, ss[i-1]); end
            end
            $display("stream cycle %0d: sum_valid=%b z=%0d sg_valid=%b sg_out=%0d", i, bus.sum_valid, $signed(bus.z), bus.sg_valid, bus.sg_out);
        end
    endtask

    task automatic test_reset_midstream();
        step(1'b1, 12'(400), 12'(500));
        step(1'b1, 12'(-700), 12'(100));
        #3 rst_n = 1'b0;
        #1;
        checks += 4;
        if (bus.sum_valid !== 1'b0) begin failures++; $display("FAIL midrst_sum_valid got=%b want=0", bus.sum_valid); end
        if (bus.z !== 12'd0)        begin failures++; $display("FAIL midrst_z got=%0d want=0", $signed(bus.z)); end
        if (bus.sg_valid !== 1'b0)  begin failures++; $display("FAIL midrst_sg_valid got=%b want=0", bus.sg_valid); end
        if (bus.sg_out !== 8'd0)    begin failures++; $display("FAIL midrst_sg_out got=%0d want=0", bus.sg_out); end
        $display("reset mid-stream: outputs cleared");
        @(posedge clk);
        #1;
        checks += 2;
        if (bus.sum_valid !== 1'b0 || bus.z !== 12'd0) begin failures++; $display("FAIL midrst_hold_sum got=%b/%0d want=0/0", bus.sum_valid, $signed(bus.z)); end
        if (bus.sg_valid !== 1'b0 || bus.sg_out !== 8'd0) begin failures++; $display("FAIL midrst_hold_sg got=%b/%0d want=0/0", bus.sg_valid, bus.sg_out); end
        m_z = '0; m_zv = 1'b0; m_sg = '0; m_sgv = 1'b0;
        bus.in_valid = 1'b0;
        bus.x = '0;
        bus.y = '0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 12'd0, 12'd0);
            checks += 3;
            if (bus.sum_valid !== 1'b0) begin failures++; $display("FAIL postrst%0d_sum_valid got=%b want=0", i, bus.sum_valid); end
            if (bus.sg_valid !== 1'b0)  begin failures++; $display("FAIL postrst%0d_sg_valid got=%b want=0", i, bus.sg_valid); end
            if (bus.z !== 12'd0)        begin failures++; $display("FAIL postrst%0d_z got=%0d want=0", i, $signed(bus.z)); end
        end
        step(1'b1, 12'(-300), 12'(-20));
        checks += 2;
        if (bus.sum_valid !== 1'b1) begin failures++; $display("FAIL postrst_first_valid got=%b want=1", bus.sum_valid); end
        if ($signed(bus.z) !== -12'sd320) begin failures++; $display("FAIL postrst_first_z got=%0d want=-320", $signed(bus.z)); end
        $display("post-reset first input: z=%0d", $signed(bus.z));
    endtask

    task automatic test_random();
        logic [11:0] rx, ry;
        logic        rv;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 5))
                0:       rx = 12'h7FF;
                1:       rx = 12'h800;
                default: rx = 12'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0:       ry = 12'h7FF;
                1:       ry = 12'h800;
                2:       ry = 12'd0;
                default: ry = 12'($urandom);
            endcase
            rv = ($urandom_range(0, 3) != 0);
            step(rv, rx, ry);
            checks += 4;
            if (bus.sum_valid !== m_zv) begin failures++; $display("FAIL rand%0d_sum_valid got=%b want=%b", i, bus.sum_valid, m_zv); end
            if (bus.z !== m_z)          begin failures++; $display("FAIL rand%0d_z got=%0d want=%0d", i, $signed(bus.z), $signed(m_z)); end
            if (bus.sg_valid !== m_sgv) begin failures++; $display("FAIL rand%0d_sg_valid got=%b want=%b", i, bus.sg_valid, m_sgv); end
            if (bus.sg_out !== m_sg)    begin failures++; $display("FAIL rand%0d_sg_out got=%0d want=%0d", i, bus.sg_out, m_sg); end
            $display("rand %0d: v=%b x=%0d y=%0d z=%0d sg_out=%0d", i, rv, $signed(rx), $signed(ry), $signed(bus.z), bus.sg_out);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midstream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
